decode_alu_unit: RTL and testbench

DECODE_ALU_UNIT -- requirements
Module: decode_alu_unit

---
 rtl/decode_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 31 +++
 rtl/decode_alu_unit.sv | 145 ++++++++++++++
 tb/tb_decode_alu_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the decode/ALU slice: opcodes, funct codes,
// ALU operation classes, ALU control codes and the control-flag bundle.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_AND   = 2'b11
  } alu_op_e;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  // Bit order matches the flag concatenation used by the bench.
  typedef struct packed {
    logic reg_dst;
    logic branch;
    logic branch_n;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic jump;
    logic alu_src;
    logic reg_write;
  } ctrl_flags_t;

  // R-type funct field to ALU control; unknown functs fall back to add.
  function automatic logic [2:0] funct_to_ctrl(input logic [5:0] funct);
    logic [2:0] ctrl;
    case (funct)
      FN_ADD:  ctrl = CTRL_ADD;
      FN_SUB:  ctrl = CTRL_SUB;
      FN_AND:  ctrl = CTRL_AND;
      FN_OR:   ctrl = CTRL_OR;
      FN_SLT:  ctrl = CTRL_SLT;
      default: ctrl = CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: and/or/add/sub/signed-less-than, wrapping arithmetic,
// zero result for the unused control codes.
module alu_core
  import decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic w_lt;

  assign w_lt = ($signed(a) < $signed(b));

  // Operation select; add/sub simply drop the carry out.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (ctrl)
      CTRL_AND: result = a & b;
      CTRL_OR:  result = a | b;
      CTRL_ADD: result = a + b;
      CTRL_SUB: result = a - b;
      CTRL_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
      default:  result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/decode_alu_unit.sv
// Instruction decode with combinational control flags feeding a
// one-cycle registered ALU result and zero flag.
module decode_alu_unit
  import decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             bubble,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             reg_dst,
  output logic             branch,
  output logic             branch_n,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             jump,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero
);

  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic             w_unused_instr;
  ctrl_flags_t      w_flags;
  alu_op_e          w_alu_op;
  logic [2:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_alu_out;
  logic [WIDTH-1:0] r_alu_result;
  logic             r_alu_zero;

  assign w_opcode       = instr[31:26];
  assign w_funct        = instr[5:0];
  assign w_unused_instr = ^instr[25:6];

  // Opcode decode; a stall or reset forces a no-op regardless of instr.
  always_comb begin
    w_flags  = '0;
    w_alu_op = ALUOP_ADD;
    if (rst || bubble) begin
      w_flags  = '0;
      w_alu_op = ALUOP_ADD;
    end else begin
      case (w_opcode)
        OP_RTYPE: begin
          w_flags.reg_dst   = 1'b1;
          w_flags.reg_write = 1'b1;
          w_alu_op          = ALUOP_FUNCT;
        end
        OP_LW: begin
          w_flags.alu_src    = 1'b1;
          w_flags.mem_read   = 1'b1;
          w_flags.mem_to_reg = 1'b1;
          w_flags.reg_write  = 1'b1;
          w_alu_op           = ALUOP_ADD;
        end
        OP_SW: begin
          w_flags.alu_src   = 1'b1;
          w_flags.mem_write = 1'b1;
          w_alu_op          = ALUOP_ADD;
        end
        OP_ADDI: begin
          w_flags.alu_src   = 1'b1;
          w_flags.reg_write = 1'b1;
          w_alu_op          = ALUOP_ADD;
        end
        OP_ANDI: begin
          w_flags.alu_src   = 1'b1;
          w_flags.reg_write = 1'b1;
          w_alu_op          = ALUOP_AND;
        end
        OP_BEQ: begin
          w_flags.branch = 1'b1;
          w_alu_op       = ALUOP_SUB;
        end
        OP_BNE: begin
          w_flags.branch_n = 1'b1;
          w_alu_op         = ALUOP_SUB;
        end
        OP_J: begin
          w_flags.jump = 1'b1;
          w_alu_op     = ALUOP_ADD;
        end
        default: begin
          w_flags  = '0;
          w_alu_op = ALUOP_ADD;
        end
      endcase
    end
  end

  // Operation class to ALU control code.
  always_comb begin
    w_alu_ctrl = CTRL_ADD;
    case (w_alu_op)
      ALUOP_ADD:   w_alu_ctrl = CTRL_ADD;
      ALUOP_SUB:   w_alu_ctrl = CTRL_SUB;
      ALUOP_AND:   w_alu_ctrl = CTRL_AND;
      ALUOP_FUNCT: w_alu_ctrl = funct_to_ctrl(w_funct);
      default:     w_alu_ctrl = CTRL_ADD;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .ctrl   (w_alu_ctrl),
    .a      (a),
    .b      (b),
    .result (w_alu_out)
  );

  // Result register; the zero flag is derived from the same value being captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_result <= {WIDTH{1'b0}};
      r_alu_zero   <= 1'b1;
    end else begin
      r_alu_result <= w_alu_out;
      r_alu_zero   <= (w_alu_out == {WIDTH{1'b0}});
    end
  end

  assign reg_dst    = w_flags.reg_dst;
  assign branch     = w_flags.branch;
  assign branch_n   = w_flags.branch_n;
  assign mem_read   = w_flags.mem_read;
  assign mem_write  = w_flags.mem_write;
  assign mem_to_reg = w_flags.mem_to_reg;
  assign jump       = w_flags.jump;
  assign alu_src    = w_flags.alu_src;
  assign reg_write  = w_flags.reg_write;
  assign alu_op     = w_alu_op;
  assign alu_ctrl   = w_alu_ctrl;
  assign alu_result = r_alu_result;
  assign alu_zero   = r_alu_zero;

endmodule

// File: tb/tb_decode_alu_unit.sv
// Directed bench: stimulus checks combinational decode immediately and queues
// the expected registered result; a monitor pops and compares one cycle later.
module tb_decode_alu_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [31:0]      instr;
  logic             bubble;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             reg_dst, branch, branch_n, mem_read, mem_write;
  logic             mem_to_reg, jump, alu_src, reg_write;
  logic [1:0]       alu_op;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  decode_alu_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .bubble     (bubble),
    .a          (a),
    .b          (b),
    .reg_dst    (reg_dst),
    .branch     (branch),
    .branch_n   (branch_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .jump       (jump),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: reg_dst branch branch_n mem_read mem_write mem_to_reg jump alu_src reg_write
  task automatic run(input string name, input logic r, input logic bub,
                     input logic [31:0] ins, input logic [WIDTH-1:0] va,
                     input logic [WIDTH-1:0] vb, input logic [8:0] e_flags,
                     input logic [1:0] e_op, input logic [2:0] e_ctrl,
                     input logic [WIDTH-1:0] e_res);
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    rst = r; bubble = bub; instr = ins; a = va; b = vb;
    e.name = name;
    e.res  = e_res;
    e.zero = (e_res == {WIDTH{1'b0}});
    exp_q.push_back(e);
    #1;
    got = {reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg, jump, alu_src, reg_write};
    tests++;
    if (got !== e_flags || alu_op !== e_op || alu_ctrl !== e_ctrl) begin
      fails++;
      $display("FAIL %s ctrl: got flags=%b op=%b ctrl=%b, expected flags=%b op=%b ctrl=%b",
               name, got, alu_op, alu_ctrl, e_flags, e_op, e_ctrl);
    end
  endtask

  // Monitor: the result of each issued vector appears right after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (alu_result !== e.res || alu_zero !== e.zero) begin
          fails++;
          $display("FAIL %s result: got %h zero=%b, expected %h zero=%b",
                   e.name, alu_result, alu_zero, e.res, e.zero);
        end
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; bubble = 1'b0; instr = 32'h0; a = '0; b = '0;
    run("reset",   1'b1, 1'b0, 32'h00221820, 32'd5, 32'd7, 9'b000000000, 2'b00, 3'b010, 32'd0);
    run("add",     1'b0, 1'b0, 32'h00221820, 32'd5, 32'd7, 9'b100000001, 2'b10, 3'b010, 32'd12);
    run("slt",     1'b0, 1'b0, 32'h0000002A, 32'hFFFFFFFF, 32'd1, 9'b100000001, 2'b10, 3'b111, 32'd1);
    run("slt_sw",  1'b0, 1'b0, 32'h0000002A, 32'd1, 32'hFFFFFFFF, 9'b100000001, 2'b10, 3'b111, 32'd0);
    run("sub",     1'b0, 1'b0, 32'h00000022, 32'd10, 32'd3, 9'b100000001, 2'b10, 3'b110, 32'd7);
    run("and",     1'b0, 1'b0, 32'h00000024, 32'h0000F0F0, 32'h0000FF00, 9'b100000001, 2'b10, 3'b000, 32'h0000F000);
    run("or",      1'b0, 1'b0, 32'h00000025, 32'h000000F0, 32'h0000000F, 9'b100000001, 2'b10, 3'b001, 32'h000000FF);
    run("fn_unk",  1'b0, 1'b0, 32'h00000000, 32'd2, 32'd3, 9'b100000001, 2'b10, 3'b010, 32'd5);
    run("lw",      1'b0, 1'b0, 32'h8C000000, 32'd100, 32'd4, 9'b000101011, 2'b00, 3'b010, 32'd104);
    run("sw",      1'b0, 1'b0, 32'hAC000000, 32'd100, 32'd8, 9'b000010010, 2'b00, 3'b010, 32'd108);
    run("addi_wr", 1'b0, 1'b0, 32'h20000000, 32'd1, 32'hFFFFFFFF, 9'b000000011, 2'b00, 3'b010, 32'd0);
    run("andi",    1'b0, 1'b0, 32'h30000000, 32'h000000FF, 32'h0000000F, 9'b000000011, 2'b11, 3'b000, 32'h0000000F);
    run("beq",     1'b0, 1'b0, 32'h10000000, 32'd9, 32'd9, 9'b010000000, 2'b01, 3'b110, 32'd0);
    run("bne",     1'b0, 1'b0, 32'h14000000, 32'd9, 32'd4, 9'b001000000, 2'b01, 3'b110, 32'd5);
    run("j",       1'b0, 1'b0, 32'h08000000, 32'd3, 32'd4, 9'b000000100, 2'b00, 3'b010, 32'd7);
    run("op_unk",  1'b0, 1'b0, 32'hFC000000, 32'd1, 32'd1, 9'b000000000, 2'b00, 3'b010, 32'd2);
    run("bubble",  1'b0, 1'b1, 32'h20000000, 32'd6, 32'd6, 9'b000000000, 2'b00, 3'b010, 32'd12);
    run("add_ovf", 1'b0, 1'b0, 32'h00221820, 32'h7FFFFFFF, 32'd1, 9'b100000001, 2'b10, 3'b010, 32'h80000000);
    run("mid_rst", 1'b1, 1'b0, 32'h00221820, 32'h7FFFFFFF, 32'd1, 9'b000000000, 2'b00, 3'b010, 32'd0);
    run("post_rst",1'b0, 1'b0, 32'h00221820, 32'h7FFFFFFF, 32'd1, 9'b100000001, 2'b10, 3'b010, 32'h80000000);
    @(negedge clk);
    rst = 1'b0; bubble = 1'b1; instr = 32'h0;
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
